adder_sub_16bit_s: RTL and testbench
====================================

// Module: adder_sub_16bit_s
// PURPOSE
//   16-bit two's-complement adder/subtractor built structurally from a ripple chain of 1-bit full adders.
//   Add_ctrl selects A+B (0) or A-B (1).
//   Produces the sum, the unsigned carry-out and the signed overflow flag.
//   Results are registered, so the block drops into a synchronous datapath as a one-stage ALU slice.
// PARAMETERS
//   WIDTH      16   operand/result width; all behaviour below is specified and verified at 16
// PORTS
//   clk        in   1      single clock, rising-edge active
//   rst_n      in   1      reset, asynchronous assert, active-low
//   A          in   16     operand A (minuend when subtracting)
//   B          in   16     operand B (subtrahend when subtracting)
//   Add_ctrl   in   1      0 = add, 1 = subtract
//   SUM        out  16     registered result, low 16 bits
//   C_out      out  1      registered carry out of bit 15; on subtract, 1 = no borrow (A >= B unsigned)
//   O          out  1      registered signed overflow flag
// BEHAVIOUR
//   - Clocking and reset: one clock; reset is asynchronous and active-low.
//   - Reset: while rst_n=0, SUM=16'h0000, C_out=0 and O=0, regardless of clk.
//     Release is synchronous to the next rising clk edge.
//   - Operand conditioning: Bx[i] = B[i] ^ Add_ctrl; carry-in c[0] = Add_ctrl.
//     Subtraction is therefore A + ~B + 1.
//   - Ripple chain, for i = 0..15:
//       s[i]   = A[i] ^ Bx[i] ^ c[i]
//       c[i+1] = A[i]&Bx[i] | c[i]&(A[i]^Bx[i])
//   - Flags: C_out_d = c[16]; O_d = c[16] ^ c[15] (signed overflow of the 16-bit two's-complement result).
//   - Latency: exactly 1 clk. The values of A, B and Add_ctrl sampled at rising edge N appear on
//     SUM, C_out and O after edge N; the outputs hold until the next edge.
//   - No handshake. A new operation can be issued every cycle (throughput 1/clk).
//   - Inputs must be stable for setup/hold around each rising edge.
//     The combinational ripple path of 16 stages is the critical path.
//   - Wrap-around: the result is modulo 2^16, with no saturation. For example, FFFF+0001 = 0000 with C_out=1.
//   - Subtract of equal operands: SUM=0000, C_out=1, O=0.
//   - Reset asserted mid-operation: outputs clear immediately and the in-flight result is discarded.
//   - No X propagation from the flags: O and C_out are always fully defined after reset.
// STRUCTURE
//   - Shared package adder_pkg: localparam WIDTH=16; ADD=1'b0 and SUB=1'b1 constants for Add_ctrl.
//   - Sub-module full_adder_1bit (a, b, cin -> s, cout), gate-level.
//     It is instantiated WIDTH times with a generate loop.
//   - Top level contains the XOR conditioning, the carry chain wiring and the overflow XOR.
//   - Top level also contains one output register bank (18 flops) with asynchronous clear.
//   - No behavioural '+' or '-' operators on the datapath; the chain must be structural.
// TESTING
//   - Reset: rst_n=0 with random inputs -> SUM=0000, C_out=0, O=0 immediately, with no clk edge needed.
//   - Add overflow: A=7FFF, B=0001, Add_ctrl=0 -> after 1 clk: SUM=8000, C_out=0, O=1.
//   - Add wrap: A=FFFF, B=0001, Add_ctrl=0 -> SUM=0000, C_out=1, O=0.
//   - Subtract with borrow: A=0003, B=0005, Add_ctrl=1 -> SUM=FFFE, C_out=0, O=0.
//     Then A=0005, B=0003 -> SUM=0002, C_out=1, O=0.
//   - Subtract overflow: A=8000, B=0001, Add_ctrl=1 -> SUM=7FFF, C_out=1, O=1.
//     Then A=0000, B=8000 -> SUM=8000, C_out=0, O=1.
//   - Random: 100 back-to-back vectors with random A, B and Add_ctrl, one per clk.
//     Each is compared against a behavioural golden model {C,SUM} = A + (B^{16{ctl}}) + ctl,
//     with O from the sign bits, and the check is 1 cycle delayed.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the 16-bit ripple adder/subtractor slice.
// Add_ctrl encodings and datapath width.
package adder_pkg;
    localparam int   WIDTH = 16;
    localparam logic ADD   = 1'b0;
    localparam logic SUB   = 1'b1;
endpackage

// File: rtl/adder_sub_16bit_s_full_adder_1bit.sv
// Gate-level 1-bit full adder, one cell of the ripple chain.
// Carry generates on a&b or propagates cin when a^b.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/adder_sub_16bit_s.sv
// Registered two's-complement add/subtract slice on a structural ripple chain.
// Subtract is A + ~B + 1 via B inversion and carry-in.
module adder_sub_16bit_s
    import adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Add_ctrl,
    output logic [WIDTH-1:0] SUM,
    output logic             C_out,
    output logic             O
);
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;
    logic             ovf;

    assign bx   = B ^ {WIDTH{Add_ctrl}};
    assign c[0] = Add_ctrl;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_1bit u_fa (
            .a    (A[i]),
            .b    (bx[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it
    assign ovf = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SUM   <= '0;
            C_out <= 1'b0;
            O     <= 1'b0;
        end else begin
            SUM   <= s;
            C_out <= c[WIDTH];
            O     <= ovf;
        end
    end
endmodule

// File: tb/tb_adder_sub_16bit_s.sv
// Self-checking bench for adder_sub_16bit_s.
// Expected results are queued at issue and compared one cycle later.
module tb_adder_sub_16bit_s;
    import adder_pkg::*;

    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        o;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        Add_ctrl;
    logic [15:0] SUM;
    logic        C_out;
    logic        O;

    res_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    adder_sub_16bit_s dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .Add_ctrl (Add_ctrl),
        .SUM      (SUM),
        .C_out    (C_out),
        .O        (O)
    );

    task automatic chk(input string tag, input logic [17:0] got,
                       input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got sum=%h c=%b o=%b, want sum=%h c=%b o=%b",
                     tag, got[17:2], got[1], got[0],
                     exp[17:2], exp[1], exp[0]);
        end
    endtask

    function automatic res_t model(input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic ctl);
        logic [15:0] bm;
        logic [16:0] t;
        res_t        r;
        bm    = b ^ {16{ctl}};
        t     = {1'b0, a} + {1'b0, bm} + {16'd0, ctl};
        r.sum = t[15:0];
        r.c   = t[16];
        r.o   = (a[15] == bm[15]) && (t[15] != a[15]);
        return r;
    endfunction

    task automatic step(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic ctl);
        res_t r;
        @(negedge clk);
        A        = a;
        B        = b;
        Add_ctrl = ctl;
        q.push_back(model(a, b, ctl));
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, "_noexp"}, {SUM, C_out, O}, 18'h3ffff);
        end else begin
            r = q.pop_front();
            chk(tag, {SUM, C_out, O}, r);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        A        = 16'($urandom);
        B        = 16'($urandom);
        Add_ctrl = 1'($urandom);
        #1;
        chk("reset_init", {SUM, C_out, O}, 18'h0);

        @(negedge clk);
        rst_n = 1'b1;

        step("add_ovf",   16'h7FFF, 16'h0001, ADD);
        chk("add_ovf_const", {SUM, C_out, O}, {16'h8000, 1'b0, 1'b1});
        step("add_wrap",  16'hFFFF, 16'h0001, ADD);
        chk("add_wrap_const", {SUM, C_out, O}, {16'h0000, 1'b1, 1'b0});
        step("sub_borrow", 16'h0003, 16'h0005, SUB);
        chk("sub_borrow_const", {SUM, C_out, O}, {16'hFFFE, 1'b0, 1'b0});
        step("sub_noborrow", 16'h0005, 16'h0003, SUB);
        chk("sub_noborrow_const", {SUM, C_out, O}, {16'h0002, 1'b1, 1'b0});
        step("sub_eq",    16'h1234, 16'h1234, SUB);
        chk("sub_eq_const", {SUM, C_out, O}, {16'h0000, 1'b1, 1'b0});
        step("sub_ovf1",  16'h8000, 16'h0001, SUB);
        chk("sub_ovf1_const", {SUM, C_out, O}, {16'h7FFF, 1'b1, 1'b1});
        step("sub_ovf2",  16'h0000, 16'h8000, SUB);
        chk("sub_ovf2_const", {SUM, C_out, O}, {16'h8000, 1'b0, 1'b1});

        // Hold check: no edge, inputs change, outputs must not move
        @(negedge clk);
        A = 16'h0001;
        B = 16'h0001;
        Add_ctrl = ADD;
        #1;
        chk("hold", {SUM, C_out, O}, {16'h8000, 1'b0, 1'b1});

        // Asynchronous reset mid-cycle clears without an edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async", {SUM, C_out, O}, 18'h0);
        @(posedge clk);
        #1;
        chk("reset_held", {SUM, C_out, O}, 18'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            step("random", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d left, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end
endmodule
